gpio_padmux: RTL
================

Name: gpio_padmux

Overview:
- Parametrised pad multiplexer that replaces hard-wired pad-to-peripheral assignment in the openframe wrapper.
- Each of N_PADS pads selects one of N_FUNC peripheral functions through Wishbone-accessible registers.
- Pad inputs are synchronised and edge-detected, with maskable rising-edge interrupts.
- Sits between the Microwatt-side peripherals (UART, JTAG, SPI, GPIO) and the gpio_in/gpio_out/gpio_oeb pad buses.

Parameters:
- N_PADS, 44, number of pads handled (1..64).
- N_FUNC, 4, functions per pad (2..16); function 0 is always "safe input" (hi-Z).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous reset, active-high
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  8  byte address, word aligned; bits [1:0] ignored
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte lanes
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  acknowledge
- fn_out  in  N_FUNC*N_PADS  per-function output data; slice k = function k
- fn_oeb  in  N_FUNC*N_PADS  per-function output enable, active-low
- fn_in  out  N_PADS  synchronised pad inputs, broadcast to all functions
- pad_in  in  N_PADS  raw pad input (gpio_in)
- pad_out  out  N_PADS  to gpio_out
- pad_oeb  out  N_PADS  to gpio_oeb
- irq  out  1  level interrupt

Behaviour:
- One clock domain (wb_clk_i). Reset is synchronous and active-high on wb_rst_i.
- Register map (byte offsets):
  - FSEL0..FSEL7 at 0x00–0x1C: 4-bit field per pad, 8 pads per word; pad p is at word p/8, bits [4*(p%8)+3 : 4*(p%8)].
  - IRQ_EN0/1 at 0x40/0x44: pads 0–31 and 32–63.
  - IRQ_STAT0/1 at 0x48/0x4C: write-1-to-clear.
  - PAD_IN0/1 at 0x50/0x54: read-only, synchronised input.
  - All bits for pads >= N_PADS read 0 and ignore writes.
- Wishbone access:
  - When cyc&stb&!ack, wb_ack_o is asserted for exactly one cycle on the next edge, so latency is 1 and acks are never back-to-back.
  - Writes honour wb_sel_i per byte. Unmapped addresses read 0, writes are dropped, and the access is still acked.
  - wb_dat_o is valid while ack=1 and is 0 otherwise.
- Function select:
  - Function 0, or any field value >= N_FUNC: pad_oeb=1, pad_out=0.
  - Function k in 1..N_FUNC-1: pad_out and pad_oeb follow slice k of fn_out and fn_oeb.
  - pad_out and pad_oeb are registered: 1-cycle latency from fn_out/fn_oeb, and from the FSEL write ack edge.
- Input path:
  - Two-flop synchroniser, then a third flop for edge detection.
  - fn_in and PAD_IN are the second-stage output, i.e. 2 cycles of latency.
  - Rising edge = stage2 & ~stage3.
- Interrupts:
  - IRQ_STAT[p] is set on a rising edge when IRQ_EN[p]=1, and cleared by writing 1.
  - If set and clear happen in the same cycle, set wins.
  - Clearing IRQ_EN does not clear a pending STAT bit.
  - irq is registered OR of all STAT bits, 1 cycle after STAT changes.
- Reset values:
  - All FSEL=0, IRQ_EN=0, IRQ_STAT=0, sync flops=0.
  - pad_out=0, pad_oeb all 1, fn_in=0, irq=0, wb_ack_o=0, wb_dat_o=0.
- Reset during a bus cycle: no ack is issued in the reset cycle, and the write is discarded.

Decomposition:
- Package gpio_padmux_pkg holds:
  - register offsets: FSEL_BASE, IRQ_EN0, IRQ_EN1, IRQ_STAT0, IRQ_STAT1, PAD_IN0, PAD_IN1;
  - FSEL_W=4 and PADS_PER_WORD=8;
  - the safe function code FUNC_SAFE=0.
- One sub-module, gpio_sync_edge, parametrised by width:
  - 3-stage synchroniser plus rising-edge pulse output;
  - instantiated once with width N_PADS.
- The mux and register file stay in the top level.

Test Plan:
1. Reset: hold wb_rst_i 3 cycles with fn_oeb=0 -> pad_oeb all 1, pad_out=0, irq=0, all register reads return 0x0000_0000.
2. Select: write FSEL1=0x0000_0002 (pad 8 -> func 2), with fn_out slice 2 bit 8 =1 and fn_oeb=0 -> ack 1 cycle after stb; next cycle pad_out[8]=1, pad_oeb[8]=0; all other pads stay hi-Z.
3. Invalid/partial writes:
   - with N_FUNC=4, write FSEL0 field for pad 0 = 0xF -> pad 0 stays hi-Z; readback returns 0xF;
   - byte write wb_sel_i=0001 of 0xFFFF_FFFF to FSEL0 changes only pads 0–1.
4. Edge interrupt:
   - set IRQ_EN0=0x0000_0010 and pulse pad_in[4] 0->1 -> IRQ_STAT0=0x10 3 cycles later, then irq=1 next cycle;
   - write IRQ_STAT0=0x10 -> irq=0.
5. Simultaneous set/clear: a W1C of bit 4 lands in the same cycle as a new detected edge on pad 4 -> STAT bit stays 1.
6. Upper pads and unmapped addresses:
   - with N_PADS=44, write IRQ_EN1=0xFFFF_FFFF -> readback 0x0000_0FFF;
   - read 0x80 -> data 0, ack asserted.

Source files
------------

// File: rtl/gpio_padmux_pkg.sv
`default_nettype none
// ============================================================================
// gpio_padmux_pkg : register offsets and field constants for gpio_padmux
// Revision 1.0
// ============================================================================
package gpio_padmux_pkg;

  localparam logic [7:0] FSEL_BASE = 8'h00;
  localparam logic [7:0] IRQ_EN0   = 8'h40;
  localparam logic [7:0] IRQ_EN1   = 8'h44;
  localparam logic [7:0] IRQ_STAT0 = 8'h48;
  localparam logic [7:0] IRQ_STAT1 = 8'h4C;
  localparam logic [7:0] PAD_IN0   = 8'h50;
  localparam logic [7:0] PAD_IN1   = 8'h54;

  localparam int FSEL_W        = 4;
  localparam int PADS_PER_WORD = 8;

  localparam logic [FSEL_W-1:0] FUNC_SAFE = 4'd0;

endpackage
`default_nettype wire

// File: rtl/gpio_sync_edge.sv
`default_nettype none
// ============================================================================
// gpio_sync_edge : two-flop synchroniser plus edge flop, rising-edge pulse out
// Revision 1.0
// ============================================================================
module gpio_sync_edge
  import gpio_padmux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = s2_q & ~s3_q;

endmodule
`default_nettype wire

// File: rtl/gpio_padmux.sv
`default_nettype none
// ============================================================================
// gpio_padmux : per-pad function select, synchronised inputs, edge interrupts
// Revision 1.0
// ============================================================================
module gpio_padmux
  import gpio_padmux_pkg::*;
#(
  parameter int N_PADS = 44,
  parameter int N_FUNC = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [7:0]               wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  input  logic [3:0]               wb_sel_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack_o,
  input  logic [N_FUNC*N_PADS-1:0] fn_out,
  input  logic [N_FUNC*N_PADS-1:0] fn_oeb,
  output logic [N_PADS-1:0]        fn_in,
  input  logic [N_PADS-1:0]        pad_in,
  output logic [N_PADS-1:0]        pad_out,
  output logic [N_PADS-1:0]        pad_oeb,
  output logic                     irq
);

  localparam int N_CODES = 2 ** FSEL_W;

  logic [N_PADS-1:0][FSEL_W-1:0] fsel_q, fsel_d;
  logic [N_PADS-1:0]             irq_en_q, irq_en_d;
  logic [N_PADS-1:0]             irq_stat_q, irq_stat_d;
  logic [N_PADS-1:0]             pad_out_q, pad_out_d;
  logic [N_PADS-1:0]             pad_oeb_q, pad_oeb_d;
  logic                          ack_q, irq_q;
  logic [31:0]                   dat_q, dat_d;

  logic [N_PADS-1:0] w_sync;
  logic [N_PADS-1:0] w_rise;
  logic [5:0]        w_word;
  logic              w_acc, w_wr;
  logic [31:0]       w_rdata;
  logic [7:0][31:0]  w_fsel_words;
  logic [1:0][31:0]  w_en_words, w_stat_words, w_pin_words;
  logic              w_unused;

  // Function 0 slices are never routed; the low address bits are don't-care.
  assign w_unused = ^{wb_adr_i[1:0], fn_out[N_PADS-1:0], fn_oeb[N_PADS-1:0]};

  gpio_sync_edge #(.WIDTH(N_PADS)) u_sync (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .d_i    (pad_in),
    .q_o    (w_sync),
    .rise_o (w_rise)
  );

  // Holding off while ack is high makes every access exactly one ack pulse.
  assign w_acc  = wb_cyc_i & wb_stb_i & ~ack_q;
  assign w_wr   = w_acc & wb_we_i;
  assign w_word = wb_adr_i[7:2];

  for (genvar p = 0; p < N_PADS; p++) begin : g_pad
    localparam int NIB = FSEL_W * (p % PADS_PER_WORD);
    localparam int BIT = p % 32;
    localparam logic [7:0] c_fsel_adr = FSEL_BASE + 8'(4 * (p / PADS_PER_WORD));
    localparam logic [7:0] c_en_adr   = (p < 32) ? IRQ_EN0 : IRQ_EN1;
    localparam logic [7:0] c_stat_adr = (p < 32) ? IRQ_STAT0 : IRQ_STAT1;

    logic               w_fsel_we, w_en_we, w_clr;
    logic [N_CODES-1:0] w_fo, w_fe;

    assign w_fsel_we = w_wr && (w_word == c_fsel_adr[7:2]) && wb_sel_i[NIB/8];
    assign w_en_we   = w_wr && (w_word == c_en_adr[7:2])   && wb_sel_i[BIT/8];
    assign w_clr     = w_wr && (w_word == c_stat_adr[7:2]) && wb_sel_i[BIT/8] && wb_dat_i[BIT];

    assign fsel_d[p]     = w_fsel_we ? wb_dat_i[NIB +: FSEL_W] : fsel_q[p];
    assign irq_en_d[p]   = w_en_we ? wb_dat_i[BIT] : irq_en_q[p];
    assign irq_stat_d[p] = (w_rise[p] & irq_en_q[p]) | (irq_stat_q[p] & ~w_clr);

    // Every possible field code gets an entry, so out-of-range codes fall to hi-Z.
    for (genvar k = 0; k < N_CODES; k++) begin : g_fn
      if (k == int'(FUNC_SAFE) || k >= N_FUNC) begin : g_safe
        assign w_fo[k] = 1'b0;
        assign w_fe[k] = 1'b1;
      end else begin : g_live
        assign w_fo[k] = fn_out[k*N_PADS + p];
        assign w_fe[k] = fn_oeb[k*N_PADS + p];
      end
    end

    assign pad_out_d[p] = w_fo[fsel_q[p]];
    assign pad_oeb_d[p] = w_fe[fsel_q[p]];
  end

  assign w_fsel_words = 256'(fsel_q);
  assign w_en_words   = 64'(irq_en_q);
  assign w_stat_words = 64'(irq_stat_q);
  assign w_pin_words  = 64'(w_sync);

  always_comb begin
    w_rdata = '0;
    case (w_word)
      IRQ_EN0[7:2]:   w_rdata = w_en_words[0];
      IRQ_EN1[7:2]:   w_rdata = w_en_words[1];
      IRQ_STAT0[7:2]: w_rdata = w_stat_words[0];
      IRQ_STAT1[7:2]: w_rdata = w_stat_words[1];
      PAD_IN0[7:2]:   w_rdata = w_pin_words[0];
      PAD_IN1[7:2]:   w_rdata = w_pin_words[1];
      default: begin
        if (wb_adr_i[7:5] == FSEL_BASE[7:5]) w_rdata = w_fsel_words[w_word[2:0]];
      end
    endcase
  end

  assign dat_d = (w_acc && !wb_we_i) ? w_rdata : '0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      fsel_q     <= {N_PADS{FUNC_SAFE}};
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      pad_out_q  <= '0;
      pad_oeb_q  <= '1;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      fsel_q     <= fsel_d;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      pad_out_q  <= pad_out_d;
      pad_oeb_q  <= pad_oeb_d;
      ack_q      <= w_acc;
      dat_q      <= dat_d;
      irq_q      <= |irq_stat_q;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign pad_out  = pad_out_q;
  assign pad_oeb  = pad_oeb_q;
  assign fn_in    = w_sync;
  assign irq      = irq_q;

endmodule
`default_nettype wire
